sysbus_mem_responder: RTL and testbench

Memory-side responder for the system bus. It accepts line-sized read and write requests from initiators such as the page-table walker, I-cache and D-cache. It returns or absorbs 8-beat, 64-byte bursts from an internal line-organised backing store. It replaces the external DRAM model in unit and subsystem benches and acts as the on-chip scratch memory behind the arbiter.

---
 rtl/sysbus_pkg.sv | 25 ++
 rtl/sysbus_line_store.sv | 35 +++
 rtl/sysbus_mem_responder.sv | 143 ++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// Shared system-bus constants: tag field layout, device codes, burst geometry
// and the memory responder state encoding.
package sysbus_pkg;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic       SYSBUS_WRITE  = 1'b0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

  localparam int TAG_RW_BIT  = 12;
  localparam int TAG_DEV_HI  = 11;
  localparam int TAG_DEV_LO  = 8;

  localparam int         BEATS_PER_LINE = 8;
  localparam int         BEAT_W         = $clog2(BEATS_PER_LINE);
  localparam int         LINE_OFFSET_W  = 6;
  localparam logic [2:0] LAST_BEAT      = 3'(BEATS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDLAT  = 2'd1,
    RDRESP = 2'd2,
    WRDATA = 2'd3
  } sysbus_state_e;

endpackage

// File: rtl/sysbus_line_store.sv
// Line-organised backing store: one bank per beat position, synchronous write,
// combinational read of the addressed word.
module sysbus_line_store #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_LINES  = 256,
  parameter int BEATS      = 8,
  parameter int LINE_W     = $clog2(MEM_LINES),
  parameter int BEAT_W     = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [LINE_W-1:0]     line,
  input  logic [BEAT_W-1:0]     beat,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] bank_rd [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] bank [MEM_LINES];

      always_ff @(posedge clk) begin
        if (wr_en && (beat == BEAT_W'(gi)))
          bank[line] <= wr_data;
      end

      assign bank_rd[gi] = bank[line];
    end
  endgenerate

  assign rd_data = bank_rd[beat];

endmodule

// File: rtl/sysbus_mem_responder.sv
// System-bus memory responder: 8-beat line reads/writes against an internal store.
// Optional request/beat tracing is compiled in with SYSBUS_MEM_TRACE_EN.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_LINES      = 256,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      main_bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] main_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
  output logic                      main_bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
  input  logic                      main_bus_respack,
  output logic                      busy
);

  localparam int LINE_W = $clog2(MEM_LINES);
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  sysbus_state_e            state_reg, state_next;
  logic [LINE_W-1:0]        line_reg, line_next;
  logic [BUS_TAG_WIDTH-1:0] tag_reg, tag_next;
  logic [BEAT_W-1:0]        beat_reg, beat_next;
  logic [3:0]               lat_reg, lat_next;

  logic                      req_is_mem;
  logic                      req_is_read;
  logic [LINE_W-1:0]         req_line;
  logic                      wr_en;
  logic [BUS_DATA_WIDTH-1:0] rd_word;

  assign req_is_mem  = (main_bus_reqtag[TAG_DEV_HI:TAG_DEV_LO] == SYSBUS_MEMORY);
  assign req_is_read = (main_bus_reqtag[TAG_RW_BIT] == SYSBUS_READ);
  // Offset bits are ignored and upper bits dropped, so addresses wrap per store size.
  assign req_line    = main_bus_req[LINE_OFFSET_W +: LINE_W];

  sysbus_line_store #(
    .DATA_WIDTH (BUS_DATA_WIDTH),
    .MEM_LINES  (MEM_LINES),
    .BEATS      (BEATS_PER_LINE),
    .LINE_W     (LINE_W),
    .BEAT_W     (BEAT_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .line    (line_reg),
    .beat    (beat_reg),
    .wr_data (main_bus_req),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      line_reg  <= '0;
      tag_reg   <= '0;
      beat_reg  <= '0;
      lat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      line_reg  <= line_next;
      tag_reg   <= tag_next;
      beat_reg  <= beat_next;
      lat_reg   <= lat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    line_next  = line_reg;
    tag_next   = tag_reg;
    beat_next  = beat_reg;
    lat_next   = lat_reg;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (main_bus_reqcyc && req_is_mem) begin
          line_next = req_line;
          beat_next = '0;
          if (req_is_read) begin
            tag_next   = main_bus_reqtag;
            lat_next   = LAT_LOAD;
            state_next = RDLAT;
          end else begin
            state_next = WRDATA;
          end
        end
      end
      RDLAT: begin
        if (lat_reg == 4'd0)
          state_next = RDRESP;
        else
          lat_next = lat_reg - 4'd1;
      end
      RDRESP: begin
        if (main_bus_respack) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT)
            state_next = IDLE;
        end
      end
      WRDATA: begin
        if (main_bus_reqcyc) begin
          wr_en     = 1'b1;
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign main_bus_respcyc = (state_reg == RDRESP);
  assign main_bus_resp    = (state_reg == RDRESP) ? rd_word : '0;
  assign main_bus_resptag = (state_reg == RDRESP) ? tag_reg : '0;
  assign busy             = (state_reg != IDLE);

`ifdef SYSBUS_MEM_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (state_reg == IDLE && main_bus_reqcyc && req_is_mem)
        $display("sysbus_mem: accept %s addr=0x%0h tag=0x%0h",
                 req_is_read ? "READ" : "WRITE", main_bus_req, main_bus_reqtag);
      if (state_reg == RDRESP && main_bus_respack)
        $display("sysbus_mem: read beat %0d data=0x%0h", beat_reg, rd_word);
      if (wr_en)
        $display("sysbus_mem: write beat %0d data=0x%0h", beat_reg, main_bus_req);
      if ((state_reg == RDLAT || state_reg == RDRESP) && main_bus_reqcyc)
        $display("sysbus_mem: dropped request addr=0x%0h tag=0x%0h while busy",
                 main_bus_req, main_bus_reqtag);
    end
  end
`endif

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: preload, reads with stalls, write-then-read,
// foreign-device filter, address wrap and reset in the middle of bursts.
module tb_sysbus_mem_responder;

  localparam logic [12:0] RD_TAG = 13'h1100;
  localparam logic [12:0] WR_TAG = 13'h0100;
  localparam int          NO_ABORT = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic        main_bus_reqcyc;
  logic [63:0] main_bus_req;
  logic [12:0] main_bus_reqtag;
  logic        main_bus_respcyc;
  logic [63:0] main_bus_resp;
  logic [12:0] main_bus_resptag;
  logic        main_bus_respack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sysbus_mem_responder dut (
    .clk              (clk),
    .reset            (reset),
    .main_bus_reqcyc  (main_bus_reqcyc),
    .main_bus_req     (main_bus_req),
    .main_bus_reqtag  (main_bus_reqtag),
    .main_bus_respcyc (main_bus_respcyc),
    .main_bus_resp    (main_bus_resp),
    .main_bus_resptag (main_bus_resptag),
    .main_bus_respack (main_bus_respack),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Address cycle then 8 data beats; optional 2-cycle gap before beat 4,
  // optional reset asserted in place of data beat 'abort'.
  task automatic write_line(input logic [63:0] addr, input logic [63:0] base,
                            input bit stall, input int abort);
    main_bus_reqcyc = 1'b1;
    main_bus_req    = addr;
    main_bus_reqtag = WR_TAG;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == abort) begin
        main_bus_reqcyc = 1'b0;
        reset = 1'b0;
        #1;
        check("wr_abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (stall && b == 4) begin
        main_bus_reqcyc = 1'b0;
        repeat (2) begin
          check("wr_stall_busy", 64'(busy), 64'd1);
          @(negedge clk);
        end
      end
      main_bus_reqcyc = 1'b1;
      main_bus_req    = base + 64'(b);
    end
    @(negedge clk);
    main_bus_reqcyc = 1'b0;
    main_bus_req    = '0;
    check("wr_done_busy", 64'(busy), 64'd0);
  endtask

  // Beats below 'split' expect base_lo+b, the rest base_hi+b.
  task automatic read_line(input logic [63:0] addr, input logic [12:0] tag,
                           input logic [63:0] base_lo, input logic [63:0] base_hi,
                           input int split, input bit stall, input int abort);
    logic [63:0] exp;
    int lat;
    main_bus_reqcyc = 1'b1;
    main_bus_req    = addr;
    main_bus_reqtag = tag;
    @(negedge clk);
    main_bus_reqcyc = 1'b0;
    main_bus_req    = '0;
    check("rd_accept_busy", 64'(busy), 64'd1);
    check("rd_early_respcyc", 64'(main_bus_respcyc), 64'd0);
    lat = 0;
    while (!main_bus_respcyc && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rd_latency", 64'(lat), 64'd4);
    for (int b = 0; b < 8; b++) begin
      exp = (b < split) ? base_lo + 64'(b) : base_hi + 64'(b);
      if (b == abort) begin
        main_bus_respack = 1'b0;
        reset = 1'b0;
        #1;
        check("rd_abort_respcyc", 64'(main_bus_respcyc), 64'd0);
        check("rd_abort_busy", 64'(busy), 64'd0);
        check("rd_abort_resp", main_bus_resp, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (stall && (b == 2 || b == 5)) begin
        main_bus_respack = 1'b0;
        repeat (3) begin
          check("rd_hold_data", main_bus_resp, exp);
          check("rd_hold_respcyc", 64'(main_bus_respcyc), 64'd1);
          @(negedge clk);
        end
      end
      check("rd_beat_data", main_bus_resp, exp);
      check("rd_beat_tag", 64'(main_bus_resptag), 64'(tag));
      $display("read addr=0x%0h beat %0d data=0x%0h tag=0x%0h",
               addr, b, main_bus_resp, main_bus_resptag);
      main_bus_respack = 1'b1;
      @(negedge clk);
    end
    main_bus_respack = 1'b0;
    check("rd_end_respcyc", 64'(main_bus_respcyc), 64'd0);
    check("rd_end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset            = 1'b0;
    main_bus_reqcyc  = 1'b0;
    main_bus_req     = '0;
    main_bus_reqtag  = '0;
    main_bus_respack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_respcyc", 64'(main_bus_respcyc), 64'd0);
    check("rst_resp", main_bus_resp, 64'd0);
    check("rst_resptag", 64'(main_bus_resptag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Preload line 0x41 and read it back with and without respack stalls.
    write_line(64'h1040, 64'h100, 1'b0, NO_ABORT);
    $display("write line 0x41 base 0x100 done");
    read_line(64'h1058, RD_TAG, 64'h100, 64'h100, 8, 1'b0, NO_ABORT);
    read_line(64'h1058, RD_TAG, 64'h100, 64'h100, 8, 1'b1, NO_ABORT);

    // Gapped write, then a read issued in the very next cycle.
    write_line(64'h2000, 64'hA0, 1'b1, NO_ABORT);
    $display("write line 0x80 base 0xA0 done");
    read_line(64'h2000, 13'h1103, 64'hA0, 64'hA0, 8, 1'b0, NO_ABORT);

    // Request for another device is ignored.
    main_bus_reqcyc = 1'b1;
    main_bus_req    = 64'h2000;
    main_bus_reqtag = 13'h1200;
    @(negedge clk);
    main_bus_reqcyc = 1'b0;
    repeat (6) begin
      check("foreign_busy", 64'(busy), 64'd0);
      check("foreign_respcyc", 64'(main_bus_respcyc), 64'd0);
      @(negedge clk);
    end
    $display("foreign device request ignored");

    // Address wraps modulo the store size.
    read_line(64'h1040 + 64'(256 * 64), RD_TAG, 64'h100, 64'h100, 8, 1'b0, NO_ABORT);

    // Reset during beat 3 of a read, then a clean read.
    read_line(64'h1040, RD_TAG, 64'h100, 64'h100, 8, 1'b0, 3);
    $display("read aborted by reset at beat 3");
    read_line(64'h1040, RD_TAG, 64'h100, 64'h100, 8, 1'b0, NO_ABORT);

    // Reset after four write beats keeps them and leaves the rest untouched.
    write_line(64'h3000, 64'hC0, 1'b0, NO_ABORT);
    write_line(64'h3000, 64'hB0, 1'b0, 4);
    $display("write aborted by reset after 4 beats");
    read_line(64'h3000, RD_TAG, 64'hB0, 64'hC0, 4, 1'b0, NO_ABORT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
